cpu_stream_arbiter: RTL

- Shares one 64-bit consumer port between CPU_NB per-CPU data sources, such as the DPI CPU servers. Arbitration is round-robin.
- Counts accepted transactions per CPU. A CPU is retired after TXN_PER_CPU transactions. all_done is raised once every CPU has finished and the last beat has been delivered.
- Sits between the per-CPU source stubs and the single checker/logger stage in the top-level bench.

---
 rtl/cpu_arb_pkg.sv | 23 ++
 rtl/cpu_stream_arbiter_rr_picker.sv | 53 +++++
 rtl/cpu_stream_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_arb_pkg
// Description : Shared sizing helpers and defaults for the CPU stream
//               arbiter and its round-robin picker.
//               idx_w(n) : width of a binary index into n items (min 1)
//               cnt_w(q) : width of a counter able to hold 0..q
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_arb_pkg;

  localparam int DEFAULT_DATA_W = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int q);
    return $clog2(q + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_stream_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Purely combinational round-robin picker. Returns the first
//               requester at or after ptr_i (wrapping modulo N).
// Ports       : req_i   [N]   request vector
//               ptr_i   [IW]  index where the scan starts (must be < N)
//               grant_o [N]   one-hot grant, all-zero when nothing requests
//               idx_o   [IW]  binary index of the granted requester
//               any_o         at least one requester present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import cpu_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Doubling the request vector turns the wrap-around scan into a plain
  // shift: bit k of rot is requester (ptr_i + k) mod N.
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    pos;

  assign dbl = {req_i, req_i};
  assign rot = N'(dbl >> ptr_i);

  always_comb begin
    any_o = 1'b0;
    pos   = '0;
    // Descending scan so the lowest offset (highest priority) wins last.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        pos   = {1'b0, ptr_i} + (IW+1)'(k);
      end
    end
    if (pos >= (IW+1)'(N)) begin
      pos = pos - (IW+1)'(N);
    end
    idx_o   = pos[IW-1:0];
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_stream_arbiter
// Description : Round-robin arbiter sharing one DATA_W-bit consumer port
//               between CPU_NB sources. Each CPU is retired after
//               TXN_PER_CPU accepted beats; all_done_o rises once every CPU
//               is retired and the output register has drained.
// Ports       : clk_i          clock
//               rst_ni         synchronous reset, active low
//               restart_i      synchronous clear of counters and done flags
//               in_valid_i     [CPU_NB]        per-CPU valid
//               in_data_i      [CPU_NB*DATA_W] per-CPU payload, CPU i at
//                                              [i*DATA_W +: DATA_W]
//               in_ready_o     [CPU_NB]        per-CPU accept (one-hot/zero)
//               out_valid_o    output beat valid
//               out_data_o     [DATA_W]  granted payload
//               out_idx_o      [IW]      source CPU of the beat
//               out_txn_o      [CW]      per-CPU transaction index, 0-based
//               out_ready_i    consumer accept
//               cpu_done_o     [CPU_NB]  CPU i reached its quota
//               all_done_o     all CPUs done and output drained
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_stream_arbiter
  import cpu_arb_pkg::*;
#(
  parameter  int CPU_NB      = 4,
  parameter  int TXN_PER_CPU = 1000,
  parameter  int DATA_W      = DEFAULT_DATA_W,
  localparam int IW          = idx_w(CPU_NB),
  localparam int CW          = cnt_w(TXN_PER_CPU)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     restart_i,
  input  logic [CPU_NB-1:0]        in_valid_i,
  input  logic [CPU_NB*DATA_W-1:0] in_data_i,
  output logic [CPU_NB-1:0]        in_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [IW-1:0]            out_idx_o,
  output logic [CW-1:0]            out_txn_o,
  input  logic                     out_ready_i,
  output logic [CPU_NB-1:0]        cpu_done_o,
  output logic                     all_done_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [IW-1:0]     out_idx_q,   out_idx_d;
  logic [CW-1:0]     out_txn_q,   out_txn_d;
  logic [CPU_NB-1:0] cpu_done_q,  cpu_done_d;
  logic              all_done_q,  all_done_d;
  logic [IW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CW-1:0]     count_q [CPU_NB];
  logic [CW-1:0]     count_d [CPU_NB];

  // --------------------------------------------------------------------------
  // Grant
  // --------------------------------------------------------------------------
  logic [CPU_NB-1:0] elig;
  logic [CPU_NB-1:0] grant;
  logic [IW-1:0]     gidx;
  logic              gany;
  logic              load;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  assign elig = in_valid_i & ~cpu_done_q;
  // The output register can take a new beat when empty or being consumed.
  assign load = ~out_valid_q | out_ready_i;
  // restart suppresses the grant for its cycle.
  assign accept = load & gany & ~restart_i;

  rr_picker #(
    .N (CPU_NB)
  ) u_picker (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  assign in_ready_o = accept ? grant : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (grant[i]) begin
        sel_data = in_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_txn_d   = out_txn_q;
    cpu_done_d  = cpu_done_q;
    all_done_d  = all_done_q;
    rr_ptr_d    = rr_ptr_q;
    for (int i = 0; i < CPU_NB; i++) begin
      count_d[i] = count_q[i];
    end

    if (restart_i) begin
      // Pending beat still drains; only bookkeeping is cleared.
      for (int i = 0; i < CPU_NB; i++) begin
        count_d[i] = '0;
      end
      cpu_done_d = '0;
      all_done_d = 1'b0;
      if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_idx_d   = gidx;
        out_txn_d   = count_q[gidx];
        if (count_q[gidx] != CW'(TXN_PER_CPU)) begin
          count_d[gidx] = count_q[gidx] + CW'(1);
        end
        if (count_q[gidx] == CW'(TXN_PER_CPU - 1)) begin
          cpu_done_d[gidx] = 1'b1;
        end
        rr_ptr_d = (gidx == IW'(CPU_NB - 1)) ? '0 : gidx + IW'(1);
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
      all_done_d = (&cpu_done_d) & ~out_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_txn_q   <= '0;
      cpu_done_q  <= '0;
      all_done_q  <= 1'b0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < CPU_NB; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_txn_q   <= out_txn_d;
      cpu_done_q  <= cpu_done_d;
      all_done_q  <= all_done_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < CPU_NB; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_txn_o   = out_txn_q;
  assign cpu_done_o  = cpu_done_q;
  assign all_done_o  = all_done_q;

endmodule
`default_nettype wire
